// File: rtl/arb_mux_n_pkg.sv
// Shared constants for arb_mux_n: selection mode encodings and the flattened-channel
// slice convention (channel i lives at bits [i*WIDTH +: WIDTH]).
package arb_mux_n_pkg;

    localparam logic [1:0] MODE_EXPLICIT = 2'b00;
    localparam logic [1:0] MODE_PRIORITY = 2'b01;
    localparam logic [1:0] MODE_RR       = 2'b10;

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Rotating-start arbiter: finds the first set request at or after start, wrapping modulo N.
// Returns a one-hot grant and its encoded index.
module arb_mux_n_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] start,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [SELW:0]  off;
    logic [SELW:0]  idx_wide;

    // Doubling the request vector turns the wrapped search into a plain window select.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[start +: N];

    always_comb begin
        gnt_valid = 1'b0;
        off       = '0;
        // Descending scan so the lowest rotated position is the last (winning) assignment.
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                gnt_valid = 1'b1;
                off       = (SELW + 1)'(j);
            end
        end
        idx_wide = {1'b0, start} + off;
        if (idx_wide >= (SELW + 1)'(N)) begin
            idx_wide = idx_wide - (SELW + 1)'(N);
        end
        gnt_idx = idx_wide[SELW-1:0];
        gnt     = '0;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N:1 selector with valid/ready on every channel; explicit, fixed-priority and
// round-robin selection feeding a single-slot output register.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load;
    logic [SELW-1:0]  arb_start;
    logic [N-1:0]     arb_gnt;
    logic [SELW-1:0]  arb_idx;
    logic             arb_valid;
    logic [N-1:0]     exp_gnt;
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  win_idx;
    logic             any_gnt;
    logic [WIDTH-1:0] mux_data;

    assign load = !out_valid_q || out_ready;

    // Fixed priority is round robin pinned to start 0.
    assign arb_start = (mode == MODE_RR) ? rr_ptr_q : '0;

    arb_mux_n_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .start     (arb_start),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        exp_gnt = '0;
        // An out-of-range sel matches no channel, so it never grants.
        for (int i = 0; i < N; i++) begin
            exp_gnt[i] = (sel == SELW'(i)) && in_valid[i];
        end
        if (mode == MODE_EXPLICIT) begin
            gnt     = exp_gnt;
            win_idx = sel;
            any_gnt = |exp_gnt;
        end else begin
            gnt     = arb_gnt;
            win_idx = arb_idx;
            any_gnt = arb_valid;
        end
    end

    assign in_ready = (load && !reset) ? gnt : '0;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[slice_lsb(i, WIDTH) +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = any_gnt;
            if (any_gnt) begin
                out_data_d = mux_data;
                out_src_d  = win_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_d = (win_idx == SELW'(N - 1)) ? '0 : win_idx + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
